// File: rtl/get_angle_360_16.sv
// rtl/get_angle_360_16.sv - angle in degrees (0..359) from a signed 16-bit unit-amplitude (sin, cos) pair
//
// Ports:
//   clk_in    in   1   clock, rising edge
//   rst_n_in  in   1   asynchronous active-low reset
//   sin_i     in  16   signed sine component
//   cos_i     in  16   signed cosine component
//   valid_i   in   1   input pair valid
//   ready_o   out  1   block can accept (IDLE only)
//   angle_o   out  9   result angle 0..359
//   valid_o   out  1   result valid, held until accepted
//   ready_i   in   1   downstream accepts result
//   err_o     out  1   near-zero input flag (only with GET_ANGLE_360_16_ZERO_DET_EN)
//
// Optional feature macro: GET_ANGLE_360_16_ZERO_DET_EN
// Fixed latency: result valid 9 cycles after the accepting edge.
// The first-octant sine table (0..45 deg, round(32767*sin)) is a combinational constant ROM.

module get_angle_360_16 (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] sin_i,
    input  logic [15:0] cos_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [8:0]  angle_o,
    output logic        valid_o,
    input  logic        ready_i
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
    ,
    output logic        err_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_SRCH = 3'd2,
        S_RND  = 3'd3,
        S_FOLD = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    // round(32767*sin(i deg)), i = 0..45; indices above 45 read as 0 and are never selected
    function automatic logic [15:0] sin_rom(input logic [5:0] i);
        case (i)
            6'd0:  sin_rom = 16'd0;
            6'd1:  sin_rom = 16'd572;
            6'd2:  sin_rom = 16'd1144;
            6'd3:  sin_rom = 16'd1715;
            6'd4:  sin_rom = 16'd2286;
            6'd5:  sin_rom = 16'd2856;
            6'd6:  sin_rom = 16'd3425;
            6'd7:  sin_rom = 16'd3993;
            6'd8:  sin_rom = 16'd4560;
            6'd9:  sin_rom = 16'd5126;
            6'd10: sin_rom = 16'd5690;
            6'd11: sin_rom = 16'd6252;
            6'd12: sin_rom = 16'd6813;
            6'd13: sin_rom = 16'd7371;
            6'd14: sin_rom = 16'd7927;
            6'd15: sin_rom = 16'd8481;
            6'd16: sin_rom = 16'd9032;
            6'd17: sin_rom = 16'd9580;
            6'd18: sin_rom = 16'd10126;
            6'd19: sin_rom = 16'd10668;
            6'd20: sin_rom = 16'd11207;
            6'd21: sin_rom = 16'd11743;
            6'd22: sin_rom = 16'd12275;
            6'd23: sin_rom = 16'd12803;
            6'd24: sin_rom = 16'd13328;
            6'd25: sin_rom = 16'd13848;
            6'd26: sin_rom = 16'd14364;
            6'd27: sin_rom = 16'd14876;
            6'd28: sin_rom = 16'd15383;
            6'd29: sin_rom = 16'd15886;
            6'd30: sin_rom = 16'd16384;
            6'd31: sin_rom = 16'd16876;
            6'd32: sin_rom = 16'd17364;
            6'd33: sin_rom = 16'd17846;
            6'd34: sin_rom = 16'd18323;
            6'd35: sin_rom = 16'd18794;
            6'd36: sin_rom = 16'd19260;
            6'd37: sin_rom = 16'd19720;
            6'd38: sin_rom = 16'd20173;
            6'd39: sin_rom = 16'd20621;
            6'd40: sin_rom = 16'd21062;
            6'd41: sin_rom = 16'd21497;
            6'd42: sin_rom = 16'd21925;
            6'd43: sin_rom = 16'd22347;
            6'd44: sin_rom = 16'd22762;
            6'd45: sin_rom = 16'd23170;
            default: sin_rom = 16'd0;
        endcase
    endfunction

    // |x| with -32768 saturated to 32767 so the magnitude stays inside the table range
    function automatic logic [15:0] abs_sat(input logic [15:0] x);
        if (x == 16'h8000)
            abs_sat = 16'h7fff;
        else if (x[15])
            abs_sat = 16'd0 - x;
        else
            abs_sat = x;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] sin_q, sin_d;
    logic [15:0] cos_q, cos_d;
    logic        s_neg_q, s_neg_d;
    logic        c_neg_q, c_neg_d;
    logic        swap_q, swap_d;
    logic [15:0] m_q, m_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [8:0]  angle_q, angle_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
    logic        small_q, small_d;
    logic        err_q, err_d;
`endif

    logic [5:0]  t;
    logic [15:0] abs_s, abs_c;
    logic [15:0] rom_t, rom_i, rom_n;
    logic [16:0] d_lo, d_hi;
    logic [8:0]  a9;

    always_comb begin
        state_d = state_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        s_neg_d = s_neg_q;
        c_neg_d = c_neg_q;
        swap_d  = swap_q;
        m_d     = m_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        angle_d = angle_q;
        valid_d = valid_q;
        ready_d = ready_q;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
        small_d = small_q;
        err_d   = err_q;
`endif

        t     = idx_q | (6'd1 << bit_q);
        abs_s = abs_sat(sin_q);
        abs_c = abs_sat(cos_q);
        rom_t = sin_rom(t);
        rom_i = sin_rom(idx_q);
        rom_n = sin_rom(idx_q + 6'd1);
        // m >= table[idx] after the search, and table[idx+1] > m whenever idx < 45
        d_lo  = {1'b0, m_q} - {1'b0, rom_i};
        d_hi  = {1'b0, rom_n} - {1'b0, m_q};
        a9    = swap_q ? (9'd90 - {3'd0, idx_q}) : {3'd0, idx_q};

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    sin_d   = sin_i;
                    cos_d   = cos_i;
                    ready_d = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                s_neg_d = sin_q[15];
                c_neg_d = cos_q[15];
                swap_d  = (abs_s > abs_c);
                m_d     = (abs_s > abs_c) ? abs_c : abs_s;
                idx_d   = 6'd0;
                bit_d   = 3'd5;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
                small_d = (abs_s < 16'd64) && (abs_c < 16'd64);
`endif
                state_d = S_SRCH;
            end
            S_SRCH: begin
                // one successive-approximation bit per cycle, MSB first
                if ((t <= 6'd45) && (rom_t <= m_q))
                    idx_d = t;
                if (bit_q == 3'd0)
                    state_d = S_RND;
                else
                    bit_d = bit_q - 3'd1;
            end
            S_RND: begin
                // ties keep the lower index
                if ((idx_q < 6'd45) && (d_lo > d_hi))
                    idx_d = idx_q + 6'd1;
                state_d = S_FOLD;
            end
            S_FOLD: begin
                case ({s_neg_q, c_neg_q})
                    2'b00:   angle_d = a9;
                    2'b01:   angle_d = 9'd180 - a9;
                    2'b11:   angle_d = 9'd180 + a9;
                    default: angle_d = (a9 == 9'd0) ? 9'd0 : (9'd360 - a9);
                endcase
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
                err_d = small_q;
                if (small_q)
                    angle_d = 9'd0;
`endif
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            sin_q   <= 16'd0;
            cos_q   <= 16'd0;
            s_neg_q <= 1'b0;
            c_neg_q <= 1'b0;
            swap_q  <= 1'b0;
            m_q     <= 16'd0;
            idx_q   <= 6'd0;
            bit_q   <= 3'd0;
            angle_q <= 9'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
            small_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            s_neg_q <= s_neg_d;
            c_neg_q <= c_neg_d;
            swap_q  <= swap_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            angle_q <= angle_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
            small_q <= small_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign angle_o = angle_q;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
    assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_get_angle_360_16.sv
// tb/tb_get_angle_360_16.sv - directed-vector bench for get_angle_360_16

module tb_get_angle_360_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sin_i = 16'd0;
    logic [15:0] cos_i = 16'd0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [8:0]  angle_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
    logic        err_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    get_angle_360_16 dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .sin_i    (sin_i),
        .cos_i    (cos_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .angle_o  (angle_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
`ifdef GET_ANGLE_360_16_ZERO_DET_EN
        ,
        .err_o    (err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0)
            return $rtoi($floor(x + 0.5 + 1.0e-6));
        else
            return -$rtoi($floor(-x + 0.5 + 1.0e-6));
    endfunction

    // drive one pair and let it be accepted on the next rising edge (edge k)
    task automatic start(input logic [15:0] s, input logic [15:0] c);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        sin_i   = s;
        cos_i   = c;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // edges after the accepting edge until valid_o is seen; -1 on timeout
    task automatic wait_valid(output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                lat = i;
                break;
            end
            if (ready_o)
                busy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] s, input logic [15:0] c,
                           input int exp, input logic full);
        int   lat;
        logic busy_ok;
        start(s, c);
        wait_valid(lat, busy_ok);
        chk(tag, angle_o, exp);
        if (full) begin
            chk({tag, "_lat"}, lat, 9);
            chk({tag, "_busy"}, busy_ok, 1'b1);
        end
        @(posedge clk);
        #1;
        if (full) begin
            chk({tag, "_vdrop"}, valid_o, 1'b0);
            chk({tag, "_rdy"}, ready_o, 1'b1);
        end
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic [8:0] held;
        real  pi;
        int   sv, cv;
        pi = 3.14159265358979323846;

        #12;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_angle", angle_o, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("a30",  16'd16384, 16'd28377, 30, 1'b1);
        run_vec("a120", 16'd28377, -16'sd16384, 120, 1'b1);
        run_vec("a225", -16'sd23170, -16'sd23170, 225, 1'b0);
        run_vec("a0",   16'd0, 16'd32767, 0, 1'b0);
        run_vec("a90",  16'd32767, 16'd0, 90, 1'b0);
        run_vec("a180", 16'd0, -16'sd32767, 180, 1'b0);
        run_vec("a270", -16'sd32767, 16'd0, 270, 1'b0);
        run_vec("wrap360", -16'sd1, 16'd32767, 0, 1'b0);
        run_vec("sat270", 16'h8000, 16'd0, 270, 1'b0);
        run_vec("a45",  16'd23170, 16'd23170, 45, 1'b0);
        run_vec("a315", -16'sd23170, 16'd23170, 315, 1'b0);
`ifndef GET_ANGLE_360_16_ZERO_DET_EN
        run_vec("zero", 16'd0, 16'd0, 0, 1'b0);
`endif

        // backpressure: result held while ready_i is low, valid_i ignored
        ready_i = 1'b0;
        start(16'd16384, 16'd28377);
        wait_valid(lat, busy_ok);
        chk("bp_lat", lat, 9);
        held = angle_o;
        chk("bp_angle", held, 30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sin_i   = 16'd32767;
            cos_i   = 16'd0;
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            chk("bp_valid", valid_o, 1'b1);
            chk("bp_hold", angle_o, 30);
            chk("bp_nrdy", ready_o, 1'b0);
        end
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", valid_o, 1'b0);
        chk("bp_ready", ready_o, 1'b1);

        // reset during the search phase
        start(16'd28377, -16'sd16384);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_ready", ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        busy_ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (valid_o)
                busy_ok = 1'b0;
        end
        chk("no_stale", busy_ok, 1'b1);
        run_vec("post_rst", 16'd32767, 16'd0, 90, 1'b1);

`ifdef GET_ANGLE_360_16_ZERO_DET_EN
        start(16'd10, -16'sd20);
        wait_valid(lat, busy_ok);
        chk("zd_lat", lat, 9);
        chk("zd_err", err_o, 1'b1);
        chk("zd_angle", angle_o, 0);
        @(posedge clk);
        #1;
        start(16'd16384, 16'd28377);
        wait_valid(lat, busy_ok);
        chk("zd_err_clr", err_o, 1'b0);
        chk("zd_a30", angle_o, 30);
        @(posedge clk);
        #1;
`endif

        // full-circle sweep
        for (int n = 0; n < 360; n++) begin
            sv = rnd(32767.0 * $sin(n * pi / 180.0));
            cv = rnd(32767.0 * $cos(n * pi / 180.0));
            run_vec($sformatf("sweep%0d", n), sv[15:0], cv[15:0], n, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
